// File: rtl/ib_ctrl_pkg.sv
// Shared definitions for the IB iteration controller and the downstream write FSMs:
// busy handshake codes and the controller state encoding.
package ib_ctrl_pkg;

   localparam logic [1:0] BUSY_IDLE = 2'b00;
   localparam logic [1:0] BUSY_RUN  = 2'b01;
   localparam logic [1:0] BUSY_FIN  = 2'b10;
   localparam logic [1:0] BUSY_ILL  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RQST    = 3'd1,
      ST_RELEASE = 3'd2,
      ST_DECIDE  = 3'd3,
      ST_TERM    = 3'd4,
      ST_DONE    = 3'd5
   } ctrl_state_e;

   // States in which the controller waits on the write FSMs and the watchdog runs.
   function automatic logic is_wait_state(input ctrl_state_e s);
      return (s == ST_RQST) || (s == ST_RELEASE);
   endfunction

endpackage

// File: rtl/ib_busy_reduce.sv
// Reduces the packed per-FSM busy codes to the three handshake summaries
// used by the iteration controller.
module ib_busy_reduce
   import ib_ctrl_pkg::*;
#(
   parameter int FSM_NUM = 3
) (
   input  logic [2*FSM_NUM-1:0] busy_i,
   output logic                 all_fin_o,
   output logic                 all_idle_o,
   output logic                 any_illegal_o
);

   always_comb begin
      all_fin_o     = 1'b1;
      all_idle_o    = 1'b1;
      any_illegal_o = 1'b0;
      for (int k = 0; k < FSM_NUM; k++) begin
         all_fin_o     = all_fin_o  & (busy_i[2*k +: 2] == BUSY_FIN);
         all_idle_o    = all_idle_o & (busy_i[2*k +: 2] == BUSY_IDLE);
         any_illegal_o = any_illegal_o | (busy_i[2*k +: 2] == BUSY_ILL);
      end
   end

endmodule

// File: rtl/ib_iter_ctrl.sv
// Iteration controller: sequences one IB-map update per decoding iteration across
// the write FSMs and ends the frame on max-iteration, early stop, abort or timeout.
module ib_iter_ctrl
   import ib_ctrl_pkg::*;
#(
   parameter  int MAX_ITER       = 10,
   parameter  int FSM_NUM        = 3,
   parameter  int TIMEOUT_CYCLES = 1023,
   localparam int ITER_W         = $clog2(MAX_ITER + 1)
) (
   input  logic                 write_clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 early_stop,
   input  logic                 abort,
   input  logic [2*FSM_NUM-1:0] busy_in,
   output logic                 iter_rqst,
   output logic                 iter_termination,
   output logic [ITER_W-1:0]    iter_cnt,
   output logic                 ctrl_busy,
   output logic                 done,
   output logic                 err_timeout,
   output logic                 err_illegal
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   ctrl_state_e        state_q, state_d;
   logic [TMO_W-1:0]   tmo_q;
   logic [ITER_W-1:0]  iter_cnt_q;
   logic               es_lat_q, ab_lat_q;
   logic               err_timeout_q, err_illegal_q;
   logic               iter_rqst_q, iter_term_q, ctrl_busy_q, done_q;

   logic all_fin, all_idle, any_illegal;
   logic start_acc, tmo_hit;

   ib_busy_reduce #(.FSM_NUM(FSM_NUM)) u_busy_reduce (
      .busy_i        (busy_in),
      .all_fin_o     (all_fin),
      .all_idle_o    (all_idle),
      .any_illegal_o (any_illegal)
   );

   assign start_acc = (state_q == ST_IDLE) && start;
   assign tmo_hit   = is_wait_state(state_q) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (start) state_d = ST_RQST;
         // A completed handshake takes precedence over a watchdog expiring in the same cycle.
         ST_RQST: begin
            if (all_fin)      state_d = ST_RELEASE;
            else if (tmo_hit) state_d = ST_TERM;
         end
         ST_RELEASE: begin
            if (all_idle)     state_d = ST_DECIDE;
            else if (tmo_hit) state_d = ST_TERM;
         end
         ST_DECIDE: begin
            if ((iter_cnt_q == ITER_W'(MAX_ITER)) || es_lat_q || ab_lat_q) state_d = ST_TERM;
            else                                                            state_d = ST_RQST;
         end
         ST_TERM:    state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         tmo_q         <= '0;
         iter_cnt_q    <= '0;
         es_lat_q      <= 1'b0;
         ab_lat_q      <= 1'b0;
         err_timeout_q <= 1'b0;
         err_illegal_q <= 1'b0;
         iter_rqst_q   <= 1'b0;
         iter_term_q   <= 1'b0;
         ctrl_busy_q   <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q <= state_d;

         if ((state_d != state_q) || !is_wait_state(state_q)) tmo_q <= '0;
         else                                                  tmo_q <= tmo_q + TMO_W'(1);

         if (start_acc) begin
            iter_cnt_q    <= '0;
            es_lat_q      <= 1'b0;
            ab_lat_q      <= 1'b0;
            err_timeout_q <= 1'b0;
         end else begin
            if ((state_q == ST_RQST) && early_stop)                 es_lat_q <= 1'b1;
            else if ((state_q == ST_DECIDE) && (state_d == ST_RQST)) es_lat_q <= 1'b0;
            // Abort only latches here; it is acted on at the next DECIDE so no FSM is cut mid-fetch.
            if ((state_q != ST_IDLE) && abort) ab_lat_q <= 1'b1;
            if ((state_q == ST_RELEASE) && all_idle && (iter_cnt_q < ITER_W'(MAX_ITER)))
               iter_cnt_q <= iter_cnt_q + ITER_W'(1);
            if (tmo_hit && (state_d == ST_TERM)) err_timeout_q <= 1'b1;
         end

         err_illegal_q <= (err_illegal_q && !start_acc) || any_illegal;

         iter_rqst_q <= (state_d == ST_RQST);
         iter_term_q <= (state_d == ST_TERM);
         ctrl_busy_q <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
      end
   end

   assign iter_rqst        = iter_rqst_q;
   assign iter_termination = iter_term_q;
   assign iter_cnt         = iter_cnt_q;
   assign ctrl_busy        = ctrl_busy_q;
   assign done             = done_q;
   assign err_timeout      = err_timeout_q;
   assign err_illegal      = err_illegal_q;

endmodule

// File: tb/tb_ib_iter_ctrl.sv
// Bench for ib_iter_ctrl: behavioural write-FSM models, a table of whole-frame
// scenarios, and hand-written sequences for restart, illegal code and mid-frame reset.
module tb_ib_iter_ctrl;
   import ib_ctrl_pkg::*;

   localparam int MAX_ITER   = 3;
   localparam int FSM_NUM    = 3;
   localparam int TMO        = 16;
   localparam int LOAD_CYCLE = 4;
   localparam int ITER_W     = $clog2(MAX_ITER + 1);

   logic                 write_clk = 1'b0;
   logic                 rstn = 1'b0;
   logic                 start = 1'b0;
   logic                 early_stop = 1'b0;
   logic                 abort = 1'b0;
   logic [2*FSM_NUM-1:0] busy_in;
   logic                 iter_rqst, iter_termination, ctrl_busy, done, err_timeout, err_illegal;
   logic [ITER_W-1:0]    iter_cnt;

   int checks = 0;
   int errors = 0;

   logic [1:0] mst   [FSM_NUM];
   int         mcnt  [FSM_NUM];
   bit         stuck [FSM_NUM];
   bit         force_ill [FSM_NUM];

   ib_iter_ctrl #(.MAX_ITER(MAX_ITER), .FSM_NUM(FSM_NUM), .TIMEOUT_CYCLES(TMO)) dut (
      .write_clk        (write_clk),
      .rstn             (rstn),
      .start            (start),
      .early_stop       (early_stop),
      .abort            (abort),
      .busy_in          (busy_in),
      .iter_rqst        (iter_rqst),
      .iter_termination (iter_termination),
      .iter_cnt         (iter_cnt),
      .ctrl_busy        (ctrl_busy),
      .done             (done),
      .err_timeout      (err_timeout),
      .err_illegal      (err_illegal)
   );

   always #5 write_clk = ~write_clk;

   // Write-FSM model: load takes LOAD_CYCLE cycles, FINISH held until the request drops.
   always @(posedge write_clk or negedge rstn) begin
      for (int k = 0; k < FSM_NUM; k++) begin
         if (!rstn) begin
            mst[k]  <= BUSY_IDLE;
            mcnt[k] <= 0;
         end else begin
            case (mst[k])
               BUSY_IDLE: if (iter_rqst) begin mst[k] <= BUSY_RUN; mcnt[k] <= 0; end
               BUSY_RUN: begin
                  if (iter_termination)            mst[k]  <= BUSY_IDLE;
                  else if (mcnt[k] == LOAD_CYCLE-1) mst[k] <= BUSY_FIN;
                  else                              mcnt[k] <= mcnt[k] + 1;
               end
               BUSY_FIN: if (!iter_rqst || iter_termination) mst[k] <= BUSY_IDLE;
               default:  mst[k] <= BUSY_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      busy_in = '0;
      for (int k = 0; k < FSM_NUM; k++)
         busy_in[2*k +: 2] = force_ill[k] ? BUSY_ILL : (stuck[k] ? BUSY_RUN : mst[k]);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   typedef struct {
      int es_it;     // window in which early_stop is held high (0 = never)
      int ab_it;     // window whose first cycle carries an abort pulse (0 = never)
      bit stuck0;    // FSM 0 reports 01 for the whole frame
      int exp_win;
      int exp_wlen;
      int exp_cnt;
      int exp_tmo;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input int idx);
      int  win, wlen, terms, dones, cnt, tmo, busy_after;
      bit  prev, ended;
      win = 0; wlen = 0; terms = 0; dones = 0; cnt = -1; tmo = -1; busy_after = -1;
      prev = 1'b0; ended = 1'b0;
      stuck[0] = vecs[idx].stuck0;
      @(negedge write_clk) start = 1'b1;
      @(negedge write_clk) start = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         abort = 1'b0;
         if (iter_rqst && !prev) begin
            win++;
            if (win == vecs[idx].ab_it) abort = 1'b1;
         end
         if (iter_rqst && win == 1) wlen++;
         prev = iter_rqst;
         early_stop = iter_rqst && (win == vecs[idx].es_it);
         if (iter_termination) begin
            terms++;
            chk($sformatf("v%0d_rqst_in_term", idx), int'(iter_rqst), 0);
         end
         if (done) begin
            dones++;
            cnt = int'(iter_cnt);
            tmo = int'(err_timeout);
         end else if (dones > 0) begin
            busy_after = int'(ctrl_busy);
            ended = 1'b1;
            break;
         end
         @(negedge write_clk);
      end
      early_stop = 1'b0;
      abort      = 1'b0;
      stuck[0]   = 1'b0;
      chk($sformatf("v%0d_frame_ended", idx), int'(ended), 1);
      chk($sformatf("v%0d_rqst_windows", idx), win, vecs[idx].exp_win);
      chk($sformatf("v%0d_first_window_len", idx), wlen, vecs[idx].exp_wlen);
      chk($sformatf("v%0d_term_pulses", idx), terms, 1);
      chk($sformatf("v%0d_done_pulses", idx), dones, 1);
      chk($sformatf("v%0d_iter_cnt", idx), cnt, vecs[idx].exp_cnt);
      chk($sformatf("v%0d_err_timeout", idx), tmo, vecs[idx].exp_tmo);
      chk($sformatf("v%0d_busy_after_done", idx), busy_after, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rqst"}, int'(iter_rqst), 0);
      chk({tag, "_term"}, int'(iter_termination), 0);
      chk({tag, "_cnt"}, int'(iter_cnt), 0);
      chk({tag, "_busy"}, int'(ctrl_busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_err_tmo"}, int'(err_timeout), 0);
      chk({tag, "_err_ill"}, int'(err_illegal), 0);
   endtask

   initial begin
      int  win;
      bit  prev, hit;

      //            es ab st win wlen cnt tmo
      vecs[0] = '{0, 0, 0, 3, 6,  3, 0};   // full frame to MAX_ITER
      vecs[1] = '{2, 0, 0, 2, 6,  2, 0};   // early stop in 2nd iteration
      vecs[2] = '{0, 1, 0, 1, 6,  1, 0};   // abort during ROM fetch of iteration 1
      vecs[3] = '{0, 0, 1, 1, TMO, 0, 1};  // stuck FSM -> watchdog
      vecs[4] = '{0, 0, 0, 3, 6,  3, 0};   // next start clears err_timeout
      vecs[5] = '{3, 0, 0, 3, 6,  3, 0};   // early stop coincides with MAX_ITER

      for (int k = 0; k < FSM_NUM; k++) begin stuck[k] = 1'b0; force_ill[k] = 1'b0; end

      #3;
      chk_all_zero("reset");
      repeat (3) @(negedge write_clk);
      rstn = 1'b1;
      repeat (2) @(negedge write_clk);

      for (int i = 0; i < 6; i++) begin
         run_vec(i);
         repeat (3) @(negedge write_clk);
      end

      // Restart attempt mid-frame and an illegal busy code.
      @(negedge write_clk) start = 1'b1;
      @(negedge write_clk) start = 1'b0;
      win = 0; prev = 1'b0; hit = 1'b0;
      for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
         if (iter_rqst && !prev) win++;
         prev = iter_rqst;
         if (win == 2) hit = 1'b1;
         else @(negedge write_clk);
      end
      chk("restart_reached_win2", int'(hit), 1);
      chk("restart_cnt_before", int'(iter_cnt), 1);
      start = 1'b1;
      @(negedge write_clk) start = 1'b0;
      chk("restart_cnt_after", int'(iter_cnt), 1);
      chk("restart_rqst_held", int'(iter_rqst), 1);
      chk("restart_busy", int'(ctrl_busy), 1);
      force_ill[1] = 1'b1;
      @(negedge write_clk) force_ill[1] = 1'b0;
      chk("illegal_set", int'(err_illegal), 1);
      hit = 1'b0;
      for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
         @(negedge write_clk);
         if (done) hit = 1'b1;
      end
      chk("illegal_frame_done", int'(hit), 1);
      chk("illegal_sticky", int'(err_illegal), 1);
      chk("restart_final_cnt", int'(iter_cnt), MAX_ITER);
      repeat (2) @(negedge write_clk);
      run_vec(0);
      chk("illegal_cleared_by_start", int'(err_illegal), 0);
      repeat (2) @(negedge write_clk);

      // Asynchronous reset in RELEASE of iteration 2.
      @(negedge write_clk) start = 1'b1;
      @(negedge write_clk) start = 1'b0;
      win = 0; prev = 1'b0; hit = 1'b0;
      for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
         if (iter_rqst && !prev) win++;
         if (!iter_rqst && prev && win == 2) hit = 1'b1;
         prev = iter_rqst;
         if (!hit) @(negedge write_clk);
      end
      chk("rst_reached_release2", int'(hit), 1);
      chk("rst_cnt_before", int'(iter_cnt), 1);
      chk("rst_busy_before", int'(ctrl_busy), 1);
      #1 rstn = 1'b0;
      #1 chk_all_zero("midrst");
      @(negedge write_clk) rstn = 1'b1;
      repeat (2) @(negedge write_clk);
      run_vec(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
